// File: rtl/ibex_rf_ecc_scrubber_if.sv
// Register-file side bus of the ECC scrubber: scrub read port with same-cycle decoder
// result, writeback request to the shared write port, and the snooped core write strobe.
interface ibex_rf_ecc_scrubber_if;
  logic        core_we_i;
  logic [4:0]  core_waddr_i;
  logic [4:0]  scrub_raddr_o;
  logic        scrub_err_i;
  logic        scrub_dbl_i;
  logic [31:0] scrub_cdata_i;
  // scrub_we_o is the request valid; the shared port is ready only while core_we_i is low.
  // A request is taken in any cycle where scrub_we_o=1, which the scrubber raises only when
  // core_we_i=0; otherwise it holds waddr/wdata and retries in the next cycle.
  logic        scrub_we_o;
  logic [4:0]  scrub_waddr_o;
  logic [31:0] scrub_wdata_o;

  modport master (
    input  core_we_i, core_waddr_i, scrub_err_i, scrub_dbl_i, scrub_cdata_i,
    output scrub_raddr_o, scrub_we_o, scrub_waddr_o, scrub_wdata_o
  );

  modport slave (
    output core_we_i, core_waddr_i, scrub_err_i, scrub_dbl_i, scrub_cdata_i,
    input  scrub_raddr_o, scrub_we_o, scrub_waddr_o, scrub_wdata_o
  );
endinterface

// File: rtl/ibex_rf_ecc_scrubber.sv
// Background ECC scrubber for the register file: walks words 1..NumWords-1, rewrites
// correctable words and flags uncorrectable ones. Macro IBEX_RF_SCRUB_STATS_EN adds counters.
module ibex_rf_ecc_scrubber #(
  parameter int unsigned NumWords       = 32,
  parameter int unsigned IntervalCycles = 1024,
  parameter int unsigned CntWidth       = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    scrub_en_i,
  ibex_rf_ecc_scrubber_if.master  rf,
  output logic [CntWidth-1:0]     corr_cnt_o,
  output logic [CntWidth-1:0]     uncorr_cnt_o,
  output logic                    alert_o,
  output logic                    pass_done_o,
  output logic [2:0]              dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_READ  = 3'd2,
    S_CHECK = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  localparam logic [4:0]  LastAddr   = 5'(NumWords - 1);
  localparam logic [15:0] FirstLoad  = 16'(IntervalCycles - 1);
  localparam logic [15:0] RepeatLoad = 16'(IntervalCycles);

  state_e      r_state, w_state_nxt;
  logic [4:0]  r_addr, w_addr_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_stale, w_stale_nxt;
  logic        r_err, r_dbl;
  logic [31:0] r_cdata;
  logic        w_collide;
  logic        w_advance;

  assign w_collide   = rf.core_we_i && (rf.core_waddr_i == r_addr);
  assign dbg_state_o = r_state;

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_cnt_nxt        = r_cnt;
    w_stale_nxt      = r_stale;
    w_advance        = 1'b0;
    rf.scrub_raddr_o = 5'd0;
    rf.scrub_we_o    = 1'b0;
    rf.scrub_waddr_o = 5'd0;
    rf.scrub_wdata_o = 32'd0;
    alert_o          = 1'b0;
    pass_done_o      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (scrub_en_i) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = FirstLoad;
        end
      end
      S_WAIT: begin
        if (r_cnt == 16'd0) w_state_nxt = S_READ;
        else                w_cnt_nxt   = r_cnt - 16'd1;
      end
      S_READ: begin
        rf.scrub_raddr_o = r_addr;
        w_stale_nxt      = r_stale | w_collide;
        w_state_nxt      = S_CHECK;
      end
      S_CHECK: begin
        w_stale_nxt = r_stale | w_collide;
        if (r_dbl) begin
          alert_o   = 1'b1;
          w_advance = 1'b1;
        end else if (r_err) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_advance = 1'b1;
        end
      end
      S_WRITE: begin
        rf.scrub_waddr_o = r_addr;
        rf.scrub_wdata_o = r_cdata;
        // A core write to this word makes the corrected data obsolete: give up on it.
        if (r_stale || w_collide) begin
          w_advance = 1'b1;
        end else if (!rf.core_we_i) begin
          rf.scrub_we_o = 1'b1;
          w_advance     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_advance) begin
      w_addr_nxt  = (r_addr == LastAddr) ? 5'd1 : r_addr + 5'd1;
      pass_done_o = (r_addr == LastAddr);
      w_stale_nxt = 1'b0;
      w_cnt_nxt   = RepeatLoad;
      w_state_nxt = S_WAIT;
    end

    // Disabling abandons the current word without side effects; it is rescanned on resume.
    if (!scrub_en_i) begin
      w_state_nxt   = S_IDLE;
      w_addr_nxt    = r_addr;
      w_stale_nxt   = 1'b0;
      w_cnt_nxt     = 16'd0;
      rf.scrub_we_o = 1'b0;
      alert_o       = 1'b0;
      pass_done_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_addr  <= 5'd1;
      r_cnt   <= 16'd0;
      r_stale <= 1'b0;
      r_err   <= 1'b0;
      r_dbl   <= 1'b0;
      r_cdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stale <= w_stale_nxt;
      if (r_state == S_READ) begin
        r_err   <= rf.scrub_err_i;
        r_dbl   <= rf.scrub_dbl_i;
        r_cdata <= rf.scrub_cdata_i;
      end
    end
  end

`ifdef IBEX_RF_SCRUB_STATS_EN
  logic [CntWidth-1:0] r_corr_cnt, r_uncorr_cnt;

  // A taken writeback is exactly one corrected word; an alert is exactly one uncorrectable word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      if (rf.scrub_we_o && (r_corr_cnt != {CntWidth{1'b1}}))
        r_corr_cnt <= r_corr_cnt + CntWidth'(1);
      if (alert_o && (r_uncorr_cnt != {CntWidth{1'b1}}))
        r_uncorr_cnt <= r_uncorr_cnt + CntWidth'(1);
    end
  end

  assign corr_cnt_o   = r_corr_cnt;
  assign uncorr_cnt_o = r_uncorr_cnt;
`else
  assign corr_cnt_o   = '0;
  assign uncorr_cnt_o = '0;
`endif

endmodule
